l2_tcdm_responder: RTL and testbench



---
 rtl/l2_tcdm_responder.sv | 144 ++++++++++++++
 tb/tb_l2_tcdm_responder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_tcdm_responder.sv
// l2_tcdm_responder: TCDM slave end driving one single-port pipelined L2 SRAM bank.
// Optional macro L2_RESP_INIT_EN: zero-fill the bank after reset before accepting traffic.
module l2_tcdm_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h1C000000,
    parameter int          NUM_WORDS   = 16384,
    parameter int          MEM_LATENCY = 1,
    parameter logic [31:0] ERR_RDATA   = 32'hBADACCE5,
    localparam int         AW          = $clog2(NUM_WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          tcdm_req_i,
    input  logic [31:0]   tcdm_add_i,
    input  logic          tcdm_wen_i,
    input  logic [35:0]   tcdm_wdata_i,
    input  logic [3:0]    tcdm_be_i,
    output logic          tcdm_gnt_o,
    output logic          tcdm_r_valid_o,
    output logic [35:0]   tcdm_r_rdata_o,
    output logic          tcdm_r_opc_o,
    output logic          mem_csn_o,
    output logic          mem_wen_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [35:0]   mem_wdata_o,
    output logic [35:0]   mem_ben_o,
    input  logic [35:0]   mem_rdata_i,
    output logic          init_done_o
);

    logic                   ready;
    logic                   init_wr;
    logic [AW-1:0]          init_addr;
    logic [31:0]            off;
    logic                   in_range;
    logic                   acc;
    logic [35:0]            wr_mask;
    logic [MEM_LATENCY-1:0] pv;
    logic [MEM_LATENCY-1:0] pr;
    logic [MEM_LATENCY-1:0] pe;
    logic                   unused_off;

`ifdef L2_RESP_INIT_EN
    typedef enum logic {S_INIT, S_READY} state_t;

    state_t        state;
    logic [AW-1:0] init_cnt;

    // Zero-fill sweep: one word per cycle, then hand the bank to the master.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_INIT;
            init_cnt <= '0;
        end else if (state == S_INIT) begin
            init_cnt <= init_cnt + AW'(1);
            if (init_cnt == AW'(NUM_WORDS - 1))
                state <= S_READY;
        end
    end

    assign ready       = (state == S_READY);
    // The SRAM stays idle while reset is held, even though state sits in INIT.
    assign init_wr     = (state == S_INIT) && rst_ni;
    assign init_addr   = init_cnt;
    assign init_done_o = ready;
`else
    // No traffic is accepted while reset is held.
    assign ready       = rst_ni;
    assign init_wr     = 1'b0;
    assign init_addr   = '0;
    assign init_done_o = 1'b1;
`endif

    // Window decode; the subtraction wraps so addresses below the base fall out.
    assign off        = tcdm_add_i - BASE_ADDR;
    assign in_range   = (tcdm_add_i >= BASE_ADDR) &&
                        ({2'b00, off[31:2]} < NUM_WORDS[31:0]);
    assign unused_off = ^off[1:0];

    assign tcdm_gnt_o = tcdm_req_i & ready;
    assign acc        = tcdm_gnt_o & in_range;

    // Byte enable i covers data byte i and tag bit 32+i.
    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < 4; i++) begin
            wr_mask[8*i +: 8] = {8{tcdm_be_i[i]}};
            wr_mask[32 + i]   = tcdm_be_i[i];
        end
    end

    // SRAM port: init sweep has priority, else the granted in-window access.
    always_comb begin
        mem_csn_o   = 1'b1;
        mem_wen_o   = 1'b1;
        mem_addr_o  = off[2 +: AW];
        mem_wdata_o = tcdm_wdata_i;
        mem_ben_o   = '1;
        if (init_wr) begin
            mem_csn_o   = 1'b0;
            mem_wen_o   = 1'b0;
            mem_addr_o  = init_addr;
            mem_wdata_o = '0;
            mem_ben_o   = '0;
        end else if (acc) begin
            mem_csn_o = 1'b0;
            mem_wen_o = tcdm_wen_i;
            mem_ben_o = tcdm_wen_i ? 36'h0 : ~wr_mask;
        end
    end

    // Response shift register aligned with the SRAM read latency.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pv <= '0;
            pr <= '0;
            pe <= '0;
        end else begin
            pv[0] <= tcdm_gnt_o;
            pr[0] <= tcdm_wen_i;
            pe[0] <= ~in_range;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pr[i] <= pr[i-1];
                pe[i] <= pe[i-1];
            end
        end
    end

    // Response data is taken straight from the SRAM in the completion cycle.
    always_comb begin
        tcdm_r_valid_o = pv[MEM_LATENCY-1];
        tcdm_r_opc_o   = 1'b0;
        tcdm_r_rdata_o = '0;
        if (tcdm_r_valid_o) begin
            if (pe[MEM_LATENCY-1]) begin
                tcdm_r_opc_o   = 1'b1;
                tcdm_r_rdata_o = {4'h0, ERR_RDATA};
            end else if (pr[MEM_LATENCY-1]) begin
                tcdm_r_rdata_o = mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_l2_tcdm_responder.sv
// tb_l2_tcdm_responder: scoreboard bench, one responder at latency 1 and one at latency 3.
// Build with L2_RESP_INIT_EN defined to exercise the zero-fill sequence.
module tb_l2_tcdm_responder;

    localparam logic [31:0] BASE = 32'h1C000000;
    localparam int NA = 64;
    localparam int NB = 16;
`ifdef L2_RESP_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    typedef struct {
        int          due;
        logic [35:0] data;
        logic        opc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    rsp_t qa[$];
    rsp_t qb[$];
    logic [35:0] sha [NA];
    logic [35:0] shb [NB];

    logic        a_req, a_wen, a_gnt, a_rv, a_opc, a_csn, a_mwen, a_init;
    logic [31:0] a_add;
    logic [35:0] a_wdata, a_rdata, a_mwdata, a_mben, a_mrdata;
    logic [3:0]  a_be;
    logic [5:0]  a_maddr;

    logic        b_req, b_wen, b_gnt, b_rv, b_opc, b_csn, b_mwen, b_init;
    logic [31:0] b_add;
    logic [35:0] b_wdata, b_rdata, b_mwdata, b_mben, b_mrdata;
    logic [3:0]  b_be;
    logic [3:0]  b_maddr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    l2_tcdm_responder #(
        .BASE_ADDR(BASE), .NUM_WORDS(NA),
        .MEM_LATENCY(1), .ERR_RDATA(32'hBADACCE5)
    ) u_a (
        .clk_i(clk), .rst_ni(rst_n),
        .tcdm_req_i(a_req), .tcdm_add_i(a_add),
        .tcdm_wen_i(a_wen), .tcdm_wdata_i(a_wdata),
        .tcdm_be_i(a_be), .tcdm_gnt_o(a_gnt),
        .tcdm_r_valid_o(a_rv), .tcdm_r_rdata_o(a_rdata),
        .tcdm_r_opc_o(a_opc), .mem_csn_o(a_csn),
        .mem_wen_o(a_mwen), .mem_addr_o(a_maddr),
        .mem_wdata_o(a_mwdata), .mem_ben_o(a_mben),
        .mem_rdata_i(a_mrdata), .init_done_o(a_init)
    );

    l2_tcdm_responder #(
        .BASE_ADDR(BASE), .NUM_WORDS(NB),
        .MEM_LATENCY(3), .ERR_RDATA(32'hBADACCE5)
    ) u_b (
        .clk_i(clk), .rst_ni(rst_n),
        .tcdm_req_i(b_req), .tcdm_add_i(b_add),
        .tcdm_wen_i(b_wen), .tcdm_wdata_i(b_wdata),
        .tcdm_be_i(b_be), .tcdm_gnt_o(b_gnt),
        .tcdm_r_valid_o(b_rv), .tcdm_r_rdata_o(b_rdata),
        .tcdm_r_opc_o(b_opc), .mem_csn_o(b_csn),
        .mem_wen_o(b_mwen), .mem_addr_o(b_maddr),
        .mem_wdata_o(b_mwdata), .mem_ben_o(b_mben),
        .mem_rdata_i(b_mrdata), .init_done_o(b_init)
    );

    // SRAM models: active-low bit enables, fixed read latency.
    logic [35:0] mem_a [NA];
    logic [35:0] ra;
    always @(posedge clk) begin
        if (!a_csn) begin
            if (!a_mwen)
                mem_a[a_maddr] <= (mem_a[a_maddr] & a_mben) | (a_mwdata & ~a_mben);
            else
                ra <= mem_a[a_maddr];
        end
    end
    assign a_mrdata = ra;

    logic [35:0] mem_b [NB];
    logic [35:0] rb [3];
    always @(posedge clk) begin
        rb[1] <= rb[0];
        rb[2] <= rb[1];
        if (!b_csn) begin
            if (!b_mwen)
                mem_b[b_maddr] <= (mem_b[b_maddr] & b_mben) | (b_mwdata & ~b_mben);
            else
                rb[0] <= mem_b[b_maddr];
        end
    end
    assign b_mrdata = rb[2];

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request; check the grant-cycle SRAM port and queue the response.
    task automatic issue(input bit b, input logic wen, input logic [31:0] add,
                         input logic [35:0] wd, input logic [3:0] be);
        logic [31:0] off;
        logic [31:0] widx;
        logic        inr;
        int          idx;
        logic [35:0] m;
        rsp_t        r;
        off  = add - BASE;
        widx = {2'b00, off[31:2]};
        inr  = (add >= BASE) && (widx < 32'(b ? NB : NA));
        idx  = inr ? int'(widx) : 0;
        m = {be, {8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        if (b) begin
            b_req = 1'b1; b_add = add; b_wen = wen; b_wdata = wd; b_be = be;
        end else begin
            a_req = 1'b1; a_add = add; a_wen = wen; a_wdata = wd; a_be = be;
        end
        @(negedge clk);
        if (b) begin
            check("b_gnt", b_gnt, 1);
            check("b_csn", b_csn, !inr);
            if (inr) begin
                check("b_maddr", b_maddr, idx);
                check("b_mwen", b_mwen, wen);
                check("b_mben", b_mben, wen ? 36'h0 : ~m);
            end
        end else begin
            check("a_gnt", a_gnt, 1);
            check("a_csn", a_csn, !inr);
            if (inr) begin
                check("a_maddr", a_maddr, idx);
                check("a_mwen", a_mwen, wen);
                check("a_mben", a_mben, wen ? 36'h0 : ~m);
            end
        end
        r.due = cyc + (b ? 3 : 1);
        r.opc = !inr;
        if (!inr) begin
            r.data = {4'h0, 32'hBADACCE5};
        end else if (wen) begin
            r.data = b ? shb[idx] : sha[idx];
        end else begin
            r.data = '0;
            if (b) shb[idx] = (shb[idx] & ~m) | (wd & m);
            else   sha[idx] = (sha[idx] & ~m) | (wd & m);
        end
        if (b) qb.push_back(r);
        else   qa.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        a_req = 1'b0;
        b_req = 1'b0;
        while ((qa.size() != 0 || qb.size() != 0) && k < 50) begin
            @(posedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        check("drain_a", qa.size(), 0);
        check("drain_b", qb.size(), 0);
    endtask

    task automatic wait_init();
        int k;
        k = 0;
        while (!(a_init === 1'b1 && b_init === 1'b1) && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("init_done_a", a_init, 1);
        check("init_done_b", b_init, 1);
    endtask

    // Scoreboard pop: content and exact completion cycle.
    always @(negedge clk) begin
        rsp_t r;
        if (a_rv) begin
            check("a_rsp_expected", qa.size() != 0, 1);
            if (qa.size() != 0) begin
                r = qa.pop_front();
                check("a_rdata", a_rdata, r.data);
                check("a_opc", a_opc, r.opc);
                check("a_timing", cyc, r.due);
            end
        end else begin
            check("a_rdata_idle", a_rdata, 0);
            check("a_opc_idle", a_opc, 0);
        end
    end

    always @(negedge clk) begin
        rsp_t r;
        if (b_rv) begin
            check("b_rsp_expected", qb.size() != 0, 1);
            if (qb.size() != 0) begin
                r = qb.pop_front();
                check("b_rdata", b_rdata, r.data);
                check("b_opc", b_opc, r.opc);
                check("b_timing", cyc, r.due);
            end
        end else begin
            check("b_rdata_idle", b_rdata, 0);
            check("b_opc_idle", b_opc, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        a_req = 0; a_add = '0; a_wen = 1; a_wdata = '0; a_be = '0;
        b_req = 0; b_add = '0; b_wen = 1; b_wdata = '0; b_be = '0;
        rst_n = 1'b0;
        #2;
        a_req = 1'b1;
        a_add = BASE;
        #1;
        check("rst_gnt", a_gnt, 0);
        check("rst_rv", a_rv, 0);
        check("rst_rdata", a_rdata, 0);
        check("rst_opc", a_opc, 0);
        check("rst_csn", a_csn, 1);
        check("rst_mwen", a_mwen, 1);
        check("rst_init_a", a_init, !INIT_EN);
        check("rst_csn_b", b_csn, 1);
        check("rst_init_b", b_init, !INIT_EN);
        repeat (3) @(posedge clk);
        #1;
        a_req = 1'b0;
        rst_n = 1'b1;

`ifdef L2_RESP_INIT_EN
        for (int i = 0; i < NA; i++) sha[i] = '0;
        for (int i = 0; i < NB; i++) shb[i] = '0;
        b_req = 1'b1; b_add = BASE + 32'd28; b_wen = 1'b1; b_be = 4'hF;
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            check("init_gnt", b_gnt, 0);
            check("init_done_low", b_init, 0);
            check("init_csn", b_csn, 0);
            check("init_mwen", b_mwen, 0);
            check("init_maddr", b_maddr, i);
            check("init_mben", b_mben, 0);
            check("init_mwdata", b_mwdata, 0);
        end
        @(posedge clk);
        #1;
        check("init_done_b_rise", b_init, 1);
        issue(1, 1, BASE + 32'd28, '0, 4'hF);
        idle(1);
`endif
        wait_init();

        // Latency 1: full write then read back, back to back.
        issue(0, 0, BASE + 32'h10, 36'hA_12345678, 4'hF);
        issue(0, 1, BASE + 32'h10, '0, 4'hF);
        idle(2);

        // Partial enables over a zero word.
        issue(0, 0, BASE + 32'h20, 36'h0_00000000, 4'hF);
        issue(0, 0, BASE + 32'h20, 36'hF_FFFFFFFF, 4'b0101);
        issue(0, 1, BASE + 32'h20, '0, 4'hF);
        idle(1);

        // Out of window: just past the top, just below the base, a stray write.
        issue(0, 1, BASE + 32'(NA * 4), '0, 4'hF);
        issue(0, 1, BASE - 32'd4, '0, 4'hF);
        issue(0, 0, 32'h0000_0000, 36'h1_11111111, 4'hF);
        idle(1);

        // be=0 write leaves the word untouched.
        issue(0, 0, BASE + 32'h30, 36'h3_33333333, 4'hF);
        issue(0, 0, BASE + 32'h30, 36'hF_FFFFFFFF, 4'h0);
        issue(0, 1, BASE + 32'h33, '0, 4'hF);
        drain();

        // Latency 3: preload 8 words, then 8 back-to-back reads.
        for (int i = 0; i < 8; i++)
            issue(1, 0, BASE + 32'(4 * i), {4'(i + 1), 32'hC0DE0000 + 32'(i)}, 4'hF);
        for (int i = 0; i < 8; i++)
            issue(1, 1, BASE + 32'(4 * i), '0, 4'hF);
        drain();

        // Reset with two reads in flight: both are abandoned.
        issue(1, 1, BASE + 32'd4, '0, 4'hF);
        issue(1, 1, BASE + 32'd8, '0, 4'hF);
        b_req = 1'b0;
        rst_n = 1'b0;
        qb.delete();
        #1;
        check("b_rv_in_reset", b_rv, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef L2_RESP_INIT_EN
        for (int i = 0; i < NA; i++) sha[i] = '0;
        for (int i = 0; i < NB; i++) shb[i] = '0;
`endif
        wait_init();
        idle(6);
        issue(1, 1, BASE + 32'd12, '0, 4'hF);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
